mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 111 +++++++++++
 rtl/mem_stage.sv | 111 +++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types, opcode constants and byte-lane helpers for the memory stage.
// Covers store lane/data generation and load sign/zero extension.
package mem_stage_pkg;

    localparam int REG_COUNT     = 32;
    localparam int RF_ADDR_WIDTH = $clog2(REG_COUNT);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                     valid;
        logic [6:0]               opcode;
        logic [2:0]               funct3;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [31:0]              opr_res;
        logic [31:0]              store_data;
    } mem_stage_in_t;

    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic                     rd_we;
        logic [31:0]              rd_data;
        logic                     misaligned;
    } mem_stage_out_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    function automatic logic writes_rd(input logic [6:0] op);
        logic w;
        w = 1'b0;
        case (op)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: w = 1'b1;
            default:                     w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] data);
        logic [31:0] w;
        w = data;
        case (f3[1:0])
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {off, 3'b000};
        r = rdata;
        case (f3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_BU:   r = {24'h0, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_HU:   r = {16'h0, s[15:0]};
            F3_W:    r = rdata;
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store and
// registers the writeback bundle; non-memory results pass straight through.
import mem_stage_pkg::*;

module mem_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  mem_stage_in_t             mem_stage_in,
    output mem_stage_out_t            mem_stage_out,
    output logic                      stall,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic                      dmem_we,
    output logic [DATA_WIDTH/8-1:0]   dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     dmem_rsp_rdata
);

    localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS);

    state_t     state;
    logic       is_load;
    logic       is_store;
    logic       is_mem;
    logic       misal;
    logic       done;
    logic       rd_nz;
    logic [1:0] off;

    assign off      = mem_stage_in.opr_res[1:0];
    assign is_load  = (mem_stage_in.opcode == OPC_LOAD);
    assign is_store = (mem_stage_in.opcode == OPC_STORE);
    assign is_mem   = is_load | is_store;
    assign misal    = is_mem & is_misaligned(mem_stage_in.funct3, off);
    assign rd_nz    = (mem_stage_in.rd != ADDRESS_WIDTH'(0));

    assign done = ((state == REQ) && dmem_we && dmem_req_ready)
                | ((state == WAIT) && dmem_rsp_valid);

    assign stall = mem_stage_in.valid & is_mem & ~misal & ~done;

    // Request fields are captured on entry to REQ so they stay put while
    // the memory withholds ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= '0;
            dmem_we        <= 1'b0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            mem_stage_out  <= '0;
        end else begin
            mem_stage_out <= '0;
            unique case (state)
                IDLE: begin
                    if (mem_stage_in.valid && is_mem && !misal) begin
                        state          <= REQ;
                        dmem_req_valid <= 1'b1;
                        dmem_addr      <= {mem_stage_in.opr_res[31:2], 2'b00};
                        dmem_we        <= is_store;
                        dmem_be        <= is_store
                                          ? store_be(mem_stage_in.funct3, off)
                                          : 4'b0000;
                        dmem_wdata     <= is_store
                                          ? store_wdata(mem_stage_in.funct3,
                                                        mem_stage_in.store_data)
                                          : 32'h0;
                    end else if (mem_stage_in.valid) begin
                        mem_stage_out.valid      <= 1'b1;
                        mem_stage_out.rd         <= mem_stage_in.rd;
                        mem_stage_out.rd_we      <= !is_mem && rd_nz &&
                                                    writes_rd(mem_stage_in.opcode);
                        mem_stage_out.rd_data    <= is_mem ? 32'h0
                                                           : mem_stage_in.opr_res;
                        mem_stage_out.misaligned <= misal;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (dmem_we) begin
                            state               <= IDLE;
                            mem_stage_out.valid <= 1'b1;
                            mem_stage_out.rd    <= mem_stage_in.rd;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        state                 <= IDLE;
                        mem_stage_out.valid   <= 1'b1;
                        mem_stage_out.rd      <= mem_stage_in.rd;
                        mem_stage_out.rd_we   <= rd_nz;
                        mem_stage_out.rd_data <= load_extend(mem_stage_in.funct3,
                                                             off, dmem_rsp_rdata);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment
// and reset during an outstanding access.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    mem_stage_in_t  in_s;
    mem_stage_out_t out_s;
    logic           stall;
    logic           req_valid;
    logic           req_ready;
    logic [31:0]    addr;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic           rsp_valid;
    logic [31:0]    rdata;

    int checks = 0;
    int errors = 0;
    int stalls;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_stage_in   (in_s),
        .mem_stage_out  (out_s),
        .stall          (stall),
        .dmem_req_valid (req_valid),
        .dmem_req_ready (req_ready),
        .dmem_addr      (addr),
        .dmem_we        (we),
        .dmem_be        (be),
        .dmem_wdata     (wdata),
        .dmem_rsp_valid (rsp_valid),
        .dmem_rsp_rdata (rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] sd);
        in_s.valid      = v;
        in_s.opcode     = op;
        in_s.funct3     = f3;
        in_s.rd         = rd;
        in_s.opr_res    = res;
        in_s.store_data = sd;
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 7'b0, 3'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rdata     = 32'h0;
        idle_in();
        step();
        step();
        chk("rst_out", 32'(out_s), 32'h0);
        chk("rst_out_valid", 32'(out_s.valid), 32'h0);
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        step();

        // ADD rd=5 pass-through
        drive(1'b1, 7'b0110011, 3'b000, 5'd5, 32'h1234, 32'h0);
        chk("add_stall", 32'(stall), 32'h0);
        chk("add_req", 32'(req_valid), 32'h0);
        step();
        idle_in();
        chk("add_valid", 32'(out_s.valid), 32'h1);
        chk("add_rd", 32'(out_s.rd), 32'd5);
        chk("add_we", 32'(out_s.rd_we), 32'h1);
        chk("add_data", out_s.rd_data, 32'h1234);
        chk("add_mis", 32'(out_s.misaligned), 32'h0);

        // BEQ: pass-through that does not write a register
        drive(1'b1, 7'b1100011, 3'b000, 5'd3, 32'h1, 32'h0);
        step();
        idle_in();
        chk("beq_valid", 32'(out_s.valid), 32'h1);
        chk("beq_we", 32'(out_s.rd_we), 32'h0);

        // LB addr=0x103, ready immediate, rsp after one idle WAIT cycle
        stalls = 0;
        drive(1'b1, 7'b0000011, 3'b000, 5'd7, 32'h103, 32'h0);
        chk("lb_idle_req", 32'(req_valid), 32'h0);
        stalls += int'(stall);
        step();
        req_ready = 1'b1;
        #1;
        chk("lb_req_valid", 32'(req_valid), 32'h1);
        chk("lb_addr", addr, 32'h100);
        chk("lb_we", 32'(we), 32'h0);
        chk("lb_bubble1", 32'(out_s.valid), 32'h0);
        stalls += int'(stall);
        step();
        req_ready = 1'b0;
        #1;
        chk("lb_wait_req", 32'(req_valid), 32'h0);
        chk("lb_bubble2", 32'(out_s.valid), 32'h0);
        stalls += int'(stall);
        step();
        rsp_valid = 1'b1;
        rdata     = 32'h80FFFFFF;
        #1;
        chk("lb_done_stall", 32'(stall), 32'h0);
        stalls += int'(stall);
        step();
        rsp_valid = 1'b0;
        idle_in();
        chk("lb_stall_cycles", 32'(stalls), 32'd3);
        chk("lb_valid", 32'(out_s.valid), 32'h1);
        chk("lb_rd", 32'(out_s.rd), 32'd7);
        chk("lb_we_out", 32'(out_s.rd_we), 32'h1);
        chk("lb_data", out_s.rd_data, 32'hFFFFFF80);

        // SH addr=0x202 data=0xABCD, ready after 2 cycles in REQ
        drive(1'b1, 7'b0100011, 3'b001, 5'd0, 32'h202, 32'h0000ABCD);
        chk("sh_idle_stall", 32'(stall), 32'h1);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("sh_req_valid", 32'(req_valid), 32'h1);
            chk("sh_addr", addr, 32'h200);
            chk("sh_we", 32'(we), 32'h1);
            chk("sh_be", 32'(be), 32'hC);
            chk("sh_wdata", wdata, 32'hABCDABCD);
            chk("sh_stall", 32'(stall), 32'h1);
            step();
        end
        req_ready = 1'b1;
        #1;
        chk("sh_be_hold", 32'(be), 32'hC);
        chk("sh_wdata_hold", wdata, 32'hABCDABCD);
        chk("sh_done_stall", 32'(stall), 32'h0);
        step();
        req_ready = 1'b0;
        idle_in();
        chk("sh_valid", 32'(out_s.valid), 32'h1);
        chk("sh_rd_we", 32'(out_s.rd_we), 32'h0);
        chk("sh_req_drop", 32'(req_valid), 32'h0);

        // SB addr=0x1 data=0x5A, ready immediate
        drive(1'b1, 7'b0100011, 3'b000, 5'd0, 32'h1, 32'h1234565A);
        step();
        req_ready = 1'b1;
        #1;
        chk("sb_be", 32'(be), 32'h2);
        chk("sb_wdata", wdata, 32'h5A5A5A5A);
        chk("sb_addr", addr, 32'h0);
        step();
        req_ready = 1'b0;
        idle_in();
        chk("sb_valid", 32'(out_s.valid), 32'h1);

        // LW misaligned addr=0x101
        drive(1'b1, 7'b0000011, 3'b010, 5'd4, 32'h101, 32'h0);
        chk("lw_mis_stall", 32'(stall), 32'h0);
        step();
        idle_in();
        chk("lw_mis_req", 32'(req_valid), 32'h0);
        chk("lw_mis_valid", 32'(out_s.valid), 32'h1);
        chk("lw_mis_flag", 32'(out_s.misaligned), 32'h1);
        chk("lw_mis_we", 32'(out_s.rd_we), 32'h0);

        // Reset while in WAIT; late response must be ignored
        drive(1'b1, 7'b0000011, 3'b010, 5'd9, 32'h300, 32'h0);
        step();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        idle_in();
        chk("rstw_req", 32'(req_valid), 32'h0);
        chk("rstw_valid", 32'(out_s.valid), 32'h0);
        rsp_valid = 1'b1;
        rdata     = 32'hDEADBEEF;
        step();
        rsp_valid = 1'b0;
        chk("rstw_late_rsp", 32'(out_s.valid), 32'h0);
        chk("rstw_late_we", 32'(out_s.rd_we), 32'h0);
        drive(1'b1, 7'b0010011, 3'b000, 5'd2, 32'h77, 32'h0);
        chk("rstw_idle_stall", 32'(stall), 32'h0);
        step();
        idle_in();
        chk("rstw_idle_data", out_s.rd_data, 32'h77);

        // LHU addr=0x2 rd=0, minimum-latency response
        drive(1'b1, 7'b0000011, 3'b101, 5'd0, 32'h2, 32'h0);
        step();
        req_ready = 1'b1;
        #1;
        chk("lhu_addr", addr, 32'h0);
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rdata     = 32'hF00D0000;
        #1;
        chk("lhu_stall", 32'(stall), 32'h0);
        step();
        rsp_valid = 1'b0;
        idle_in();
        chk("lhu_valid", 32'(out_s.valid), 32'h1);
        chk("lhu_data", out_s.rd_data, 32'h0000F00D);
        chk("lhu_we", 32'(out_s.rd_we), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
